// File: rtl/age_rs.sv
// age_rs: integer reservation station with CDB wakeup and oldest-ready issue.
// Define AGE_RS_AGE_ORDER_EN for age-matrix selection; default is lowest slot.
module age_rs #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX_W = 6,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PRF_IDX_W-1:0]           in_rs1_phy,
  input  logic [PRF_IDX_W-1:0]           in_rs2_phy,
  input  logic                           in_rs1_rdy,
  input  logic                           in_rs2_rdy,
  input  logic [PAYLOAD_W-1:0]           in_payload,
  input  logic [CDB_WIDTH-1:0]           wake_valid,
  input  logic [CDB_WIDTH*PRF_IDX_W-1:0] wake_phy,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [PRF_IDX_W-1:0]           iss_rs1_phy,
  output logic [PRF_IDX_W-1:0]           iss_rs2_phy,
  output logic [PAYLOAD_W-1:0]           iss_payload,
  output logic [CNT_W-1:0]               count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;
  logic [DEPTH-1:0]     r1_q;
  logic [DEPTH-1:0]     r1_d;
  logic [DEPTH-1:0]     r2_q;
  logic [DEPTH-1:0]     r2_d;
  logic [PRF_IDX_W-1:0] t1_q [DEPTH];
  logic [PRF_IDX_W-1:0] t2_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [DEPTH];
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] sel_oh;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    fslot;
  logic             enq;
  logic             iss_fire;
  logic             enq_r1;
  logic             enq_r2;

  // Tag 0 is the hardwired x0 and never matches a CDB broadcast.
  function automatic logic hit(
    input logic [PRF_IDX_W-1:0]           tag,
    input logic [CDB_WIDTH-1:0]           wv,
    input logic [CDB_WIDTH*PRF_IDX_W-1:0] wp
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (wv[k] && (tag != '0) &&
          (wp[k*PRF_IDX_W +: PRF_IDX_W] == tag)) begin
        h = 1'b1;
      end
    end
    return h;
  endfunction

  assign elig     = valid_q & r1_q & r2_q;
  assign iss_valid = |elig;
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign count     = count_q;

  assign enq      = in_valid && in_ready && !flush;
  assign iss_fire = iss_valid && iss_ready && !flush;

  assign enq_r1 = in_rs1_rdy || (in_rs1_phy == '0) ||
                  hit(in_rs1_phy, wake_valid, wake_phy);
  assign enq_r2 = in_rs2_rdy || (in_rs2_phy == '0) ||
                  hit(in_rs2_phy, wake_valid, wake_phy);

  always_comb begin
    fslot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        fslot = IW'(i);
      end
    end
  end

`ifdef AGE_RS_AGE_ORDER_EN
  // age_q[i][j] set: entry j is older than entry i.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = elig[i] && ((age_q[i] & elig) == '0);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (iss_fire) begin
        age_d[i] = age_d[i] & ~sel_oh;
      end
    end
    if (enq) begin
      age_d[fslot] = valid_q & ~(iss_fire ? sel_oh : '0);
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  assign cand = elig;
`endif

  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel    = IW'(i);
        sel_oh = DEPTH'(1) << i;
      end
    end
  end

  assign iss_rs1_phy = iss_valid ? t1_q[sel] : '0;
  assign iss_rs2_phy = iss_valid ? t2_q[sel] : '0;
  assign iss_payload = iss_valid ? pl_q[sel] : '0;

  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit(t1_q[i], wake_valid, wake_phy)) begin
        r1_d[i] = 1'b1;
      end
      if (hit(t2_q[i], wake_valid, wake_phy)) begin
        r2_d[i] = 1'b1;
      end
    end
    if (iss_fire) begin
      valid_d = valid_d & ~sel_oh;
    end
    if (enq) begin
      valid_d[fslot] = 1'b1;
      r1_d[fslot]    = enq_r1;
      r2_d[fslot]    = enq_r2;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(enq) - CNT_W'(iss_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        t1_q[i] <= '0;
        t2_q[i] <= '0;
        pl_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      count_q <= count_d;
      if (enq) begin
        t1_q[fslot] <= in_rs1_phy;
        t2_q[fslot] <= in_rs2_phy;
        pl_q[fslot] <= in_payload;
      end
    end
  end

endmodule

// File: tb/tb_age_rs.sv
// Bench for age_rs: vector table, corner sequences, randomized model check.
// Honours AGE_RS_AGE_ORDER_EN the same way as the design.
module tb_age_rs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_rs1_phy;
  logic [5:0]  in_rs2_phy;
  logic        in_rs1_rdy;
  logic        in_rs2_rdy;
  logic [63:0] in_payload;
  logic [1:0]  wake_valid;
  logic [11:0] wake_phy;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_rs1_phy;
  logic [5:0]  iss_rs2_phy;
  logic [63:0] iss_payload;
  logic [3:0]  count;

  int n_chk = 0;
  int n_pass = 0;

  age_rs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1_phy  (in_rs1_phy),
    .in_rs2_phy  (in_rs2_phy),
    .in_rs1_rdy  (in_rs1_rdy),
    .in_rs2_rdy  (in_rs2_rdy),
    .in_payload  (in_payload),
    .wake_valid  (wake_valid),
    .wake_phy    (wake_phy),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_rs1_phy (iss_rs1_phy),
    .iss_rs2_phy (iss_rs2_phy),
    .iss_payload (iss_payload),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [5:0]  a;
    logic        ar;
    logic [5:0]  b;
    logic        br;
    logic [63:0] pl;
    logic [1:0]  wv;
    logic [11:0] wp;
    logic        ir;
    logic        eiv;
    logic [5:0]  ea;
    logic [5:0]  eb;
    logic [63:0] epl;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tv [10];

  typedef struct {
    bit          v;
    logic [5:0]  t1;
    logic [5:0]  t2;
    bit          r1;
    bit          r2;
    logic [63:0] pl;
    int          seq;
  } ment_t;

  ment_t m [8];
  int    mseq;

  function automatic vec_t mk(
    input int iv, input int a, input int ar, input int b, input int br,
    input int pl, input int wv, input int wp, input int ir,
    input int eiv, input int ea, input int eb, input int epl, input int ecnt
  );
    vec_t v;
    v.iv = 1'(iv);   v.a = 6'(a);   v.ar = 1'(ar);
    v.b = 6'(b);     v.br = 1'(br); v.pl = 64'(pl);
    v.wv = 2'(wv);   v.wp = 12'(wp); v.ir = 1'(ir);
    v.eiv = 1'(eiv); v.ea = 6'(ea); v.eb = 6'(eb);
    v.epl = 64'(epl); v.ecnt = 4'(ecnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_rs1_phy = 0; in_rs2_phy = 0;
    in_rs1_rdy = 0; in_rs2_rdy = 0; in_payload = 0;
    wake_valid = 0; wake_phy = 0; iss_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enq(input int a, input int ar, input int b, input int br,
                     input logic [63:0] pl);
    in_valid = 1; in_rs1_phy = 6'(a); in_rs1_rdy = 1'(ar);
    in_rs2_phy = 6'(b); in_rs2_rdy = 1'(br); in_payload = pl;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #2 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) m[i].v = 0;
  endtask

  function automatic bit mwoke(input logic [5:0] t);
    for (int k = 0; k < 2; k++)
      if (wake_valid[k] && t != 0 && wake_phy[k*6 +: 6] == t) return 1;
    return 0;
  endfunction

  function automatic int msel();
    int b = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef AGE_RS_AGE_ORDER_EN
        if (b < 0 || m[i].seq < m[b].seq) b = i;
`else
        if (b < 0) b = i;
`endif
      end
    end
    return b;
  endfunction

  function automatic int mcnt();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m[i].v) c++;
    return c;
  endfunction

  initial begin
    int s, f, c;
    bit fire, doenq;
    logic [63:0] exp_b;

    idle();
    mseq = 0;
    for (int i = 0; i < 8; i++) m[i].v = 0;
    #12;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_payload", iss_payload, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // iv a ar b br pl wv wp ir | eiv ea eb epl ecnt
    tv[0] = mk(1, 2, 1, 0, 0, 'hA5, 0, 0,   0, 0, 0, 0, 0,    0);
    tv[1] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 1, 2, 0, 'hA5, 1);
    tv[2] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 0, 0, 0, 0,    0);
    tv[3] = mk(1, 5, 0, 3, 1, 'h11, 0, 0,   1, 0, 0, 0, 0,    0);
    tv[4] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 0, 0, 0, 0,    1);
    tv[5] = mk(0, 0, 0, 0, 0, 0,    2, 320, 1, 0, 0, 0, 0,    1);
    tv[6] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 1, 5, 3, 'h11, 1);
    tv[7] = mk(1, 7, 0, 0, 0, 'h22, 1, 7,   1, 0, 0, 0, 0,    0);
    tv[8] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 1, 7, 0, 'h22, 1);
    tv[9] = mk(0, 0, 0, 0, 0, 0,    0, 0,   1, 0, 0, 0, 0,    0);

    for (int r = 0; r < 10; r++) begin
      in_valid = tv[r].iv; in_rs1_phy = tv[r].a; in_rs1_rdy = tv[r].ar;
      in_rs2_phy = tv[r].b; in_rs2_rdy = tv[r].br; in_payload = tv[r].pl;
      wake_valid = tv[r].wv; wake_phy = tv[r].wp; iss_ready = tv[r].ir;
      #1;
      chk($sformatf("tv%0d_iss_valid", r), 64'(iss_valid), 64'(tv[r].eiv));
      chk($sformatf("tv%0d_rs1", r), 64'(iss_rs1_phy), 64'(tv[r].ea));
      chk($sformatf("tv%0d_rs2", r), 64'(iss_rs2_phy), 64'(tv[r].eb));
      chk($sformatf("tv%0d_payload", r), iss_payload, tv[r].epl);
      chk($sformatf("tv%0d_count", r), 64'(count), 64'(tv[r].ecnt));
      chk($sformatf("tv%0d_in_ready", r), 64'(in_ready), 64'd1);
      tick();
    end
    idle();

    // Fill to capacity; overflow request must be dropped.
    for (int i = 0; i < 8; i++) begin
      enq(9, 0, 0, 0, 64'(i));
      tick();
    end
    idle();
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_iss_valid", 64'(iss_valid), 64'd0);
    enq(1, 1, 0, 0, 64'hDEAD);
    tick();
    idle();
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_iss_valid", 64'(iss_valid), 64'd0);
    wake_valid = 2'b01; wake_phy = 12'd9;
    tick();
    idle();
    chk("full_wake_iss_valid", 64'(iss_valid), 64'd1);
    chk("full_wake_payload", iss_payload, 64'd0);
    iss_ready = 1;
    #1;
    chk("iss_cycle_in_ready", 64'(in_ready), 64'd0);
    tick();
    idle();
    chk("after_iss_in_ready", 64'(in_ready), 64'd1);
    chk("after_iss_count", 64'(count), 64'd7);

    // Flush with 5 occupants and a concurrent enqueue.
    flush = 1;
    tick();
    idle();
    chk("flush0_count", 64'(count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      enq(9, 0, 0, 0, 64'(i));
      tick();
    end
    idle();
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1;
    enq(1, 1, 0, 0, 64'hBEEF);
    iss_ready = 1;
    tick();
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    tick();
    chk("flush_enq_dropped", 64'(iss_valid), 64'd0);

    // Age order: A slot0, B slot1, issue A, C reuses slot0.
    enq(1, 1, 0, 0, 64'hA);
    tick();
    enq(12, 0, 0, 0, 64'hB);
    iss_ready = 1;
    #1;
    chk("age_a_payload", iss_payload, 64'hA);
    tick();
    idle();
    enq(13, 0, 0, 0, 64'hC);
    tick();
    idle();
    chk("age_count", 64'(count), 64'd2);
    wake_valid = 2'b11; wake_phy = {6'd13, 6'd12};
    tick();
    idle();
`ifdef AGE_RS_AGE_ORDER_EN
    exp_b = 64'hB;
`else
    exp_b = 64'hC;
`endif
    chk("age_first", iss_payload, exp_b);
    iss_ready = 1;
    tick();
    chk("age_second", iss_payload, exp_b ^ 64'h7);
    tick();
    idle();
    chk("age_drained", 64'(count), 64'd0);

    // Asynchronous reset between edges.
    enq(3, 1, 4, 1, 64'h55);
    tick();
    enq(6, 1, 0, 1, 64'h66);
    tick();
    idle();
    chk("pre_rst_iss_valid", 64'(iss_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_iss_valid", 64'(iss_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_payload", iss_payload, 64'd0);
    chk("arst_rs1", 64'(iss_rs1_phy), 64'd0);
    #1 rst_n = 1;
    @(negedge clk);

    // Randomized run against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_rs1_phy = 6'($urandom_range(0, 15));
      in_rs2_phy = 6'($urandom_range(0, 15));
      in_rs1_rdy = ($urandom_range(0, 2) == 0);
      in_rs2_rdy = ($urandom_range(0, 2) == 0);
      in_payload = {$urandom, $urandom};
      wake_valid = 2'($urandom_range(0, 3));
      wake_phy   = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      iss_ready  = ($urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 39) == 0);
      #1;
      s = msel();
      c = mcnt();
      chk("rnd_iss_valid", 64'(iss_valid), 64'(s >= 0));
      chk("rnd_count", 64'(count), 64'(c));
      chk("rnd_in_ready", 64'(in_ready), 64'(c < 8));
      if (s >= 0) begin
        chk("rnd_rs1", 64'(iss_rs1_phy), 64'(m[s].t1));
        chk("rnd_rs2", 64'(iss_rs2_phy), 64'(m[s].t2));
        chk("rnd_payload", iss_payload, m[s].pl);
      end else begin
        chk("rnd_payload_idle", iss_payload, 64'd0);
      end
      fire  = (s >= 0) && iss_ready && !flush;
      doenq = in_valid && (c < 8) && !flush;
      f = -1;
      for (int i = 7; i >= 0; i--) if (!m[i].v) f = i;
      for (int i = 0; i < 8; i++) begin
        if (m[i].v && mwoke(m[i].t1)) m[i].r1 = 1;
        if (m[i].v && mwoke(m[i].t2)) m[i].r2 = 1;
      end
      if (fire) m[s].v = 0;
      if (doenq) begin
        m[f].v   = 1;
        m[f].t1  = in_rs1_phy;
        m[f].t2  = in_rs2_phy;
        m[f].r1  = in_rs1_rdy || in_rs1_phy == 0 || mwoke(in_rs1_phy);
        m[f].r2  = in_rs2_rdy || in_rs2_phy == 0 || mwoke(in_rs2_phy);
        m[f].pl  = in_payload;
        m[f].seq = mseq;
        mseq++;
      end
      if (flush) for (int i = 0; i < 8; i++) m[i].v = 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/age_rs.md
# age_rs

Parametrised integer reservation station: `DEPTH` entries, `CDB_WIDTH` wakeup ports, and oldest-ready-first issue selection. It sits between rename/dispatch and one integer functional unit, in place of the fixed-size single-wakeup RS. Operand values are not stored; the issued entry's physical source tags go to the PRF read port. The opcode, immediate, rob_id, rd_phy and rd_arch fields travel in an opaque payload.

## Interface
- `DEPTH`, 8: entry count; must be ≥2.
- `CDB_WIDTH`, 2: number of wakeup (CDB) ports.
- `PRF_IDX_W`, 6: physical register tag width.
- `PAYLOAD_W`, 64: opaque payload width.
- `CNT_W`, $clog2(DEPTH+1): occupancy counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  dispatch request.
- `in_ready`  out  1  RS can accept an entry.
- `in_rs1_phy`, `in_rs2_phy`  in  PRF_IDX_W each  source tags.
- `in_rs1_rdy`, `in_rs2_rdy`  in  1 each  source value already in the PRF.
- `in_payload`  in  PAYLOAD_W  opaque uop fields.
- `wake_valid`  in  CDB_WIDTH  per-port CDB valid.
- `wake_phy`  in  CDB_WIDTH*PRF_IDX_W  per-port rd_phy; port k is at bits [k*PRF_IDX_W +: PRF_IDX_W].
- `iss_valid`  out  1  a ready entry is presented.
- `iss_ready`  in  1  functional unit accepts.
- `iss_rs1_phy`, `iss_rs2_phy`  out  PRF_IDX_W each  tags to the PRF.
- `iss_payload`  out  PAYLOAD_W  payload of the selected entry.
- `count`  out  CNT_W  number of occupied entries.

## Operation
- Per-entry state: `valid`, `rs1_phy`, `rs1_rdy`, `rs2_phy`, `rs2_rdy`, `payload`, plus an age row (DEPTH bits) when the age-order feature is compiled in.
- Enqueue fires on `in_valid && in_ready && !flush`. The new entry is written into the lowest-index free slot.
- Source ready at enqueue: `in_rsX_rdy`, OR tag == 0 (x0), OR the tag matches any asserted `wake_phy[k]` in the same cycle (wakeup bypass).
- Wakeup: every occupied entry compares both tags against all `CDB_WIDTH` ports each cycle. A match sets the matching `rdy` bit. Matching is port-order independent, and duplicate matches are harmless.
- An entry is eligible when `valid && rs1_rdy && rs2_rdy`.
- `iss_valid` = OR of the eligible bits. Selection comes from registered state only, so wakeups and enqueues take effect for selection one cycle later.
- `iss_*` outputs are the selected entry's fields, AND-masked to 0 when `iss_valid` = 0.
- Issue fires on `iss_valid && iss_ready`; the selected entry's `valid` clears at the edge.
- `in_ready` = (`count` < DEPTH), computed from registered state. A slot freed by issue in the same cycle does not raise `in_ready` until the next cycle.
- `count` next = count + enq − iss. Simultaneous enqueue and issue leaves `count` unchanged.
- `flush`: at the next edge all `valid` bits and `count` clear. A concurrent enqueue or issue handshake is discarded. `iss_valid` may be high during the flush cycle; the downstream unit must ignore it.
- Tag 0 is never woken and is never treated as not-ready.

## Timing
- Reset (`rst_n` low, asynchronous): all `valid` and `rdy` bits = 0, `count` = 0, age rows = 0. Outputs: `iss_valid` = 0, `iss_*` = 0, `in_ready` = 1.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Enqueue with both sources ready at cycle N → `iss_valid` = 1 in cycle N+1 (minimum latency 1).
- Wakeup at cycle N of the last outstanding source → eligible in cycle N+1.
- Enqueue bypass-woken at cycle N → eligible in cycle N+1.
- Full (`count` = DEPTH): `in_ready` = 0, and `in_valid` is ignored.
- Empty: `iss_valid` = 0.
- `iss_valid` stays high while `iss_ready` is low; the selected entry may change if an older entry becomes eligible.

## Configuration
- `AGE_RS_AGE_ORDER_EN` defined: an age matrix is maintained.
  - On enqueue, the new entry's row is set to the current `valid` vector, meaning it is younger than every occupant.
  - On free, the entry's column is cleared.
  - Selection picks the eligible entry with no older eligible entry.
- `AGE_RS_AGE_ORDER_EN` undefined: no age matrix is built. Selection picks the lowest-index eligible entry; all other behaviour is identical.

## Test plan
- Reset, then enqueue tags rs1=2 (rdy=1), rs2=0 (rdy=0), payload 0xA5 → `iss_valid`=1 next cycle with `iss_rs1_phy`=2, `iss_rs2_phy`=0, `iss_payload`=0xA5; the `iss_ready` pulse brings `count` back to 0.
- Enqueue rs1=5 not ready; drive `wake_valid`=2'b10, port 1 tag=5 two cycles later → `iss_valid` rises exactly one cycle after the wake.
- Enqueue rs1=7 not ready with CDB port 0 = 7 in the same cycle → eligible the next cycle (bypass).
- Fill 8 entries with `iss_ready`=0 → `in_ready`=0 and `count`=8; a 9th `in_valid` is dropped. One issue → `in_ready`=1 the following cycle, not the same cycle.
- Age order with the macro defined: enqueue A into slot 0, B into slot 1, issue A, then enqueue C (reuses slot 0); make B and C ready together → B issues first. Without the macro, C (slot 0) issues first.
- `flush` with 5 entries plus a concurrent enqueue → `count`=0 and `iss_valid`=0 next cycle.
- Async `rst_n` pulse between edges → outputs return to reset values immediately.
